// File: rtl/toggle_hs_responder.sv
// toggle_hs_responder: two-phase toggle request/ack responder feeding a valid/ready output
module toggle_hs_responder #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack_tgl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  xfer_count,
    output logic              proto_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    logic [SYNC_STAGES-1:0] sync;
    logic [0:0]             state;
    logic                   req_s;
    logic                   req_seen;
    assign req_s = sync[SYNC_STAGES-1];
    assign out_valid = state;
    // Bring the asynchronous request toggle into the clock domain
    always_ff @(posedge clk) begin
        if (rst) sync <= '0;
        else sync <= {sync[SYNC_STAGES-2:0], req_tgl};
    end
    // Capture a new request, hold it until downstream accepts, then acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_seen   <= 1'b0;
            ack_tgl    <= 1'b0;
            out_data   <= '0;
            xfer_count <= '0;
            proto_err  <= 1'b0;
        end else if (state == IDLE) begin
            if (req_s != req_seen) begin
                out_data <= req_data;
                req_seen <= req_s;
                state    <= HOLD;
            end
        end else begin
            if (req_s != req_seen) proto_err <= 1'b1;
            if (out_ready) begin
                ack_tgl    <= ~ack_tgl;
                xfer_count <= xfer_count + CNT_W'(1);
                state      <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_toggle_hs_responder.sv
// tb_toggle_hs_responder: table, directed and randomized checks against a transaction model
module tb_toggle_hs_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_tgl = 1'b0;
    logic [7:0]  req_data = 8'h00;
    logic        out_ready = 1'b0;
    logic        ack_tgl, out_valid, proto_err;
    logic [7:0]  out_data;
    logic [15:0] xfer_count;
    logic        ack4, valid4, err4;
    logic [7:0]  data4;
    logic [3:0]  cnt4;
    int          total = 0;
    int          passed = 0;
    bit          pipe[$];
    bit          m_busy, m_seen, m_ack, m_err;
    logic [7:0]  m_data;
    int          m_cnt;

    toggle_hs_responder dut (
        .clk(clk), .rst(rst), .req_tgl(req_tgl), .req_data(req_data),
        .ack_tgl(ack_tgl), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .xfer_count(xfer_count), .proto_err(proto_err)
    );

    toggle_hs_responder #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .req_tgl(req_tgl), .req_data(req_data),
        .ack_tgl(ack4), .out_data(data4), .out_valid(valid4),
        .out_ready(out_ready), .xfer_count(cnt4), .proto_err(err4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    // Transaction view: the request level seen by the block lags req_tgl by two samples;
    // a pending transfer is captured once per new level and retired by a ready edge.
    task automatic model_edge();
        bit rs;
        if (rst) begin
            pipe.delete();
            repeat (2) pipe.push_back(1'b0);
            m_busy = 0; m_seen = 0; m_ack = 0; m_err = 0; m_data = 8'h00; m_cnt = 0;
        end else begin
            rs = pipe.pop_front();
            pipe.push_back(req_tgl);
            if (!m_busy && rs != m_seen) begin
                m_seen = rs;
                m_data = req_data;
                m_busy = 1;
            end else if (m_busy) begin
                if (rs != m_seen) m_err = 1;
                if (out_ready) begin
                    m_busy = 0;
                    m_ack  = ~m_ack;
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("valid", out_valid, m_busy);
        chk("data", out_data, m_data);
        chk("ack", ack_tgl, m_ack);
        chk("count", xfer_count, m_cnt & 16'hFFFF);
        chk("err", proto_err, m_err);
        chk("count4", cnt4, m_cnt & 15);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int budget);
        logic a0;
        a0 = ack_tgl;
        for (int i = 0; i < budget && ack_tgl == a0; i++) tick();
        chk("ack_timeout", ack_tgl != a0, 1);
    endtask

    typedef struct {
        logic       rst, tgl;
        logic [7:0] data;
        logic       rdy, v;
        logic [7:0] d;
        logic       a;
        logic [15:0] c;
    } vec_t;
    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[2] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[3] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[4] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 16'd0};
        tbl[5] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 16'd1};
        tbl[6] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 16'd1};
        // single transfer
        for (int i = 0; i < 7; i++) begin
            rst = tbl[i].rst; req_tgl = tbl[i].tgl; req_data = tbl[i].data; out_ready = tbl[i].rdy;
            tick();
            chk("tbl_valid", out_valid, tbl[i].v);
            chk("tbl_data", out_data, tbl[i].d);
            chk("tbl_ack", ack_tgl, tbl[i].a);
            chk("tbl_count", xfer_count, tbl[i].c);
        end
        // backpressure
        req_tgl = 1'b0; out_ready = 1'b0;
        do_reset();
        req_data = 8'h3C; req_tgl = 1'b1;
        repeat (3) tick();
        chk("bp_valid_rise", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid_hold", out_valid, 1);
            chk("bp_data_hold", out_data, 8'h3C);
            chk("bp_no_ack", ack_tgl, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_ack", ack_tgl, 1);
        chk("bp_count", xfer_count, 1);
        repeat (4) tick();
        chk("bp_one_ack", ack_tgl, 1);
        chk("bp_one_count", xfer_count, 1);
        // protocol violation
        req_tgl = 1'b0; out_ready = 1'b0;
        do_reset();
        req_data = 8'h11; req_tgl = 1'b1;
        repeat (3) tick();
        chk("pv_valid", out_valid, 1);
        req_data = 8'h22; req_tgl = 1'b0;
        repeat (3) tick();
        chk("pv_err", proto_err, 1);
        chk("pv_data_kept", out_data, 8'h11);
        out_ready = 1'b1;
        tick();
        chk("pv_first_done", xfer_count, 1);
        chk("pv_gap", out_valid, 0);
        tick();
        chk("pv_second_valid", out_valid, 1);
        chk("pv_second_data", out_data, 8'h22);
        tick();
        chk("pv_count2", xfer_count, 2);
        chk("pv_err_sticky", proto_err, 1);
        // wrap on the 4-bit counter
        req_tgl = 1'b0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            req_data = 8'(i); req_tgl = ~req_tgl;
            wait_ack(12);
            if (i == 14) chk("wrap_15", cnt4, 15);
            if (i == 15) chk("wrap_0", cnt4, 0);
            if (i == 16) chk("wrap_1", cnt4, 1);
        end
        chk("wrap_wide", xfer_count, 17);
        // reset mid-HOLD, then a request already high at reset release
        out_ready = 1'b0; req_data = 8'h5A; req_tgl = ~req_tgl;
        repeat (3) tick();
        chk("rh_valid", out_valid, 1);
        rst = 1'b1; req_tgl = 1'b1; req_data = 8'h77;
        tick();
        chk("rh_valid_drop", out_valid, 0);
        chk("rh_ack", ack_tgl, 0);
        chk("rh_count", xfer_count, 0);
        chk("rh_err", proto_err, 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("rh_high_req", out_valid, 1);
        chk("rh_high_data", out_data, 8'h77);
        out_ready = 1'b1;
        tick();
        chk("rh_high_ack", ack_tgl, 1);
        // back-to-back
        req_tgl = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            int low;
            logic a0;
            req_data = 8'($urandom); req_tgl = ~req_tgl;
            low = 0;
            for (int k = 0; k < 10 && !out_valid; k++) begin
                tick();
                if (!out_valid) low++;
            end
            chk("b2b_gap", low >= 1, 1);
            a0 = ack_tgl;
            tick();
            chk("b2b_ack_toggle", ack_tgl != a0, 1);
        end
        chk("b2b_count", xfer_count, 8);
        chk("b2b_ack_parity", ack_tgl, 0);
        // randomized traffic
        req_tgl = 1'b0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
            if (req_tgl == ack_tgl && $urandom_range(0, 1) == 1) begin
                req_data = 8'($urandom); req_tgl = ~req_tgl;
            end else if ($urandom_range(0, 63) == 0) begin
                req_data = 8'($urandom); req_tgl = ~req_tgl;
            end
            tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/toggle_hs_responder.md
TOGGLE_HS_RESPONDER -- requirements
Module: toggle_hs_responder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the request payload width in bits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, minimum 2, giving the number of synchronizer flops on req_tgl.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the completed-transfer counter width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have the following data and handshake ports:
- req_tgl     input   1        two-phase request; each level change is one new request.
- req_data    input   DATA_W   payload; the initiator holds it stable from its toggle until ack_tgl matches.
- ack_tgl     output  1        two-phase acknowledge; toggles once per completed transfer.
- out_data    output  DATA_W   captured payload presented downstream.
- out_valid   output  1        out_data is valid.
- out_ready   input   1        downstream accepts out_data.
- xfer_count  output  CNT_W    number of completed transfers.
- proto_err   output  1        sticky protocol-violation flag.

Function
REQ-006 req_tgl SHALL pass through a SYNC_STAGES-deep flop chain; req_s is the last stage, and no logic other than the chain SHALL use req_tgl directly.
REQ-007 The block SHALL hold register req_seen, the last req_s level accepted as a request.
REQ-008 The FSM SHALL have exactly two states:
- IDLE: out_valid=0.
- HOLD: out_valid=1.
REQ-009 In IDLE, when req_s != req_seen at an edge, the block SHALL, on that edge:
- capture req_data into out_data;
- set req_seen <= req_s;
- go to HOLD.
REQ-010 Latency: if req_tgl changes before edge k, out_valid SHALL first be 1 after edge k+SYNC_STAGES (3 edges with the default).
REQ-011 In HOLD, out_data SHALL be held constant and out_valid SHALL stay 1 until out_ready=1 at an edge.
REQ-012 At a HOLD edge with out_ready=1, the block SHALL, on that edge:
- toggle ack_tgl;
- increment xfer_count;
- go to IDLE (out_valid=0 after the edge).
REQ-013 After completion the block SHALL spend at least one cycle in IDLE, so back-to-back transfers have out_valid low for at least one cycle between them.
REQ-014 out_ready SHALL be ignored in IDLE.
REQ-015 xfer_count SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-016 In HOLD, if req_s != req_seen at an edge (initiator toggled again before ack), proto_err SHALL be set to 1 and held until reset.
REQ-017 The early toggle in REQ-016 SHALL NOT alter out_data; it SHALL be treated as a new request once the FSM returns to IDLE, capturing req_data at that time.
REQ-018 If a violation edge and completion coincide in HOLD, proto_err SHALL set and completion SHALL proceed per REQ-012.
REQ-019 ack_tgl, out_valid, out_data, xfer_count and proto_err SHALL all be driven directly from flops.

Reset
REQ-020 While rst=1 at an edge, the block SHALL set:
- all synchronizer flops, req_seen and ack_tgl to 0;
- out_valid to 0 and out_data to 0;
- xfer_count to 0 and proto_err to 0;
- the FSM to IDLE.
REQ-021 rst SHALL take priority over every other event at the same edge.
REQ-022 Reset during HOLD SHALL drop the pending transfer: no ack_tgl toggle and no count increment.
REQ-023 If req_tgl=1 when rst deasserts, the block SHALL treat it as a request (req_s=1 != req_seen=0); the initiator and this block share the same reset.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Single transfer: rst, then req_data=0xA5 and toggle req_tgl 0->1, out_ready=1 -> out_valid=1 three edges after the toggle with out_data=0xA5; ack_tgl 0->1 and xfer_count=1 one edge later.
- Backpressure: out_ready=0 for 10 cycles, then 1 -> out_valid and out_data=0x3C held all 10 cycles; exactly one ack toggle; xfer_count increments once.
- Protocol violation: second req_tgl toggle while in HOLD -> proto_err=1 (sticky); after the first completion a second transfer occurs with the new req_data; xfer_count=2.
- Wrap: CNT_W=4, 17 transfers -> xfer_count reads 15 then 0 then 1.
- Reset mid-HOLD: assert rst with out_valid=1 -> next edge out_valid=0, ack_tgl=0, xfer_count=0, proto_err=0; no ack toggle observed.
- Back-to-back: initiator toggles again immediately on each ack, out_ready held 1 -> out_valid low for at least one cycle between transfers; 8 transfers yield 8 ack toggles and xfer_count=8.
